// File: rtl/kb_led_ctrl_pkg.sv
// Shared constants, state encoding and LED byte packing for the PS/2 lock-LED sequencer.
package kb_led_ctrl_pkg;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;
  localparam logic [7:0] PS2_RSP_RESEND   = 8'hFE;

  localparam int unsigned LED_SCROLL = 0;
  localparam int unsigned LED_NUM    = 1;
  localparam int unsigned LED_CAPS   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_CMD,
    ST_WAIT_CMD_DONE,
    ST_WAIT_ACK1,
    ST_SEND_ARG,
    ST_WAIT_ARG_DONE,
    ST_WAIT_ACK2
  } state_t;

  // leds is {caps,num,scroll}; upper five bits of the LED byte stay zero
  function automatic logic [7:0] led_byte(input logic [2:0] leds);
    logic [7:0] b;
    b = '0;
    b[LED_CAPS]   = leds[2];
    b[LED_NUM]    = leds[1];
    b[LED_SCROLL] = leds[0];
    return b;
  endfunction

endpackage

// File: rtl/kb_led_ctrl_if.sv
// Transmitter handshake and receiver byte stream seen by the lock-LED sequencer.
interface kb_led_ctrl_if;
  logic       tx_req;
  logic [7:0] tx_byte;
  logic       tx_ack;
  logic       tx_done;
  logic       byte_en;
  logic [7:0] rx_byte;
  logic       rsp_consume;

  modport master (
    output tx_req, tx_byte, rsp_consume,
    input  tx_ack, tx_done, byte_en, rx_byte
  );

  modport slave (
    input  tx_req, tx_byte, rsp_consume,
    output tx_ack, tx_done, byte_en, rx_byte
  );
endinterface

// File: rtl/kb_led_ctrl_timeout.sv
// Clear/enable cycle counter; expire is high in the cycle the count reaches TIMEOUT_CYCLES-1.
module kb_led_ctrl_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 2500000,
  parameter int unsigned CNT_W          = 22
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [CNT_W-1:0] cnt;

  assign expire = en && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && !expire)
      cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/kb_led_ctrl.sv
// PS/2 lock-LED sequencer: 0xED + LED byte with ACK/resend, timeout and retry limit.
// Optional KB_LED_CTRL_INIT_EN forces one sync sequence after reset.
module kb_led_ctrl
  import kb_led_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2500000,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned CNT_W          = 22
) (
  input  logic                 clk,
  input  logic                 i_aclr,
  input  logic [2:0]           i_leds,
  kb_led_ctrl_if.master        bus,
  output logic                 o_busy,
  output logic [2:0]           o_leds_applied,
  output logic                 o_err
);

  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  state_t             state, state_n;
  logic [2:0]         target, target_n;
  logic [RETRY_W-1:0] retry, retry_n;
  logic [2:0]         applied_n;
  logic               err_n;
  logic               tx_req, consume, retry_ev, force_start;
  logic [7:0]         tx_byte;
  logic               is_ack, is_resend, waiting, expire, cmd_phase;

`ifdef KB_LED_CTRL_INIT_EN
  logic pending;
  always_ff @(posedge clk or posedge i_aclr) begin
    if (i_aclr)
      pending <= 1'b1;
    else if (state == ST_IDLE)
      pending <= 1'b0;
  end
  assign force_start = pending;
`else
  assign force_start = 1'b0;
`endif

  assign is_ack    = bus.byte_en && (bus.rx_byte == PS2_RSP_ACK);
  assign is_resend = bus.byte_en && (bus.rx_byte == PS2_RSP_RESEND);
  assign waiting   = (state == ST_WAIT_CMD_DONE) || (state == ST_WAIT_ACK1) ||
                     (state == ST_WAIT_ARG_DONE) || (state == ST_WAIT_ACK2);
  assign cmd_phase = (state == ST_WAIT_CMD_DONE) || (state == ST_WAIT_ACK1);

  kb_led_ctrl_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timeout (
    .clk    (clk),
    .rst    (i_aclr),
    .clr    (state_n != state),
    .en     (waiting),
    .expire (expire)
  );

  always_comb begin
    state_n   = state;
    target_n  = target;
    retry_n   = retry;
    applied_n = o_leds_applied;
    err_n     = o_err;
    tx_req    = 1'b0;
    tx_byte   = '0;
    consume   = 1'b0;
    retry_ev  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if ((i_leds != o_leds_applied) || force_start) begin
          target_n = i_leds;
          retry_n  = '0;
          state_n  = ST_SEND_CMD;
        end
      end
      ST_SEND_CMD: begin
        tx_req  = 1'b1;
        tx_byte = PS2_CMD_SET_LEDS;
        if (bus.tx_ack) state_n = ST_WAIT_CMD_DONE;
      end
      ST_WAIT_CMD_DONE: begin
        if (bus.tx_done) state_n = ST_WAIT_ACK1;
        else if (expire) retry_ev = 1'b1;
      end
      // A recognised response takes priority over a same-cycle timeout
      ST_WAIT_ACK1: begin
        if (is_ack) begin
          consume = 1'b1;
          retry_n = '0;
          state_n = ST_SEND_ARG;
        end else if (is_resend) begin
          consume  = 1'b1;
          retry_ev = 1'b1;
        end else if (expire) begin
          retry_ev = 1'b1;
        end
      end
      ST_SEND_ARG: begin
        tx_req  = 1'b1;
        tx_byte = led_byte(target);
        if (bus.tx_ack) state_n = ST_WAIT_ARG_DONE;
      end
      ST_WAIT_ARG_DONE: begin
        if (bus.tx_done) state_n = ST_WAIT_ACK2;
        else if (expire) retry_ev = 1'b1;
      end
      ST_WAIT_ACK2: begin
        if (is_ack) begin
          consume   = 1'b1;
          applied_n = target;
          err_n     = 1'b0;
          state_n   = ST_IDLE;
        end else if (is_resend) begin
          consume  = 1'b1;
          retry_ev = 1'b1;
        end else if (expire) begin
          retry_ev = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Abort still commits target so a keyboard that never answers cannot livelock us
    if (retry_ev) begin
      if (retry < RETRY_W'(MAX_RETRY)) begin
        retry_n = retry + RETRY_W'(1);
        state_n = cmd_phase ? ST_SEND_CMD : ST_SEND_ARG;
      end else begin
        err_n     = 1'b1;
        applied_n = target;
        state_n   = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge i_aclr) begin
    if (i_aclr) begin
      state          <= ST_IDLE;
      target         <= '0;
      retry          <= '0;
      o_leds_applied <= '0;
      o_err          <= 1'b0;
    end else begin
      state          <= state_n;
      target         <= target_n;
      retry          <= retry_n;
      o_leds_applied <= applied_n;
      o_err          <= err_n;
    end
  end

  assign bus.tx_req      = tx_req;
  assign bus.tx_byte     = tx_byte;
  assign bus.rsp_consume = consume;
  assign o_busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_kb_led_ctrl.sv
// Self-checking bench for kb_led_ctrl: vector table plus multi-cycle sequences.
// Honours KB_LED_CTRL_INIT_EN when the design is built with it.
module tb_kb_led_ctrl;

  logic       clk = 1'b0;
  logic       i_aclr;
  logic [2:0] i_leds;
  logic       o_busy;
  logic [2:0] o_leds_applied;
  logic       o_err;

  kb_led_ctrl_if bus();

  kb_led_ctrl #(
    .TIMEOUT_CYCLES (16),
    .MAX_RETRY      (3),
    .CNT_W          (5)
  ) dut (
    .clk            (clk),
    .i_aclr         (i_aclr),
    .i_leds         (i_leds),
    .bus            (bus),
    .o_busy         (o_busy),
    .o_leds_applied (o_leds_applied),
    .o_err          (o_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] sent[$];

  typedef struct packed {
    logic [2:0] leds;
    logic       be;
    logic [7:0] b;
    logic       ack;
    logic       done;
    logic       req;
    logic [7:0] txb;
    logic       busy;
    logic       cons;
    logic [2:0] app;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] leds, input logic be, input logic [7:0] b,
                     input logic ack, input logic done, input logic req, input logic [7:0] txb,
                     input logic busy, input logic cons, input logic [2:0] app, input logic err);
    vec_t v;
    v = '{leds, be, b, ack, done, req, txb, busy, cons, app, err};
    tbl.push_back(v);
  endtask

  task automatic idle_inputs();
    bus.tx_ack  = 1'b0;
    bus.tx_done = 1'b0;
    bus.byte_en = 1'b0;
    bus.rx_byte = 8'h00;
  endtask

  // Plays the keyboard/transmitter: acks every request, reports done next cycle,
  // optionally answers 0xFA. Ends after three idle cycles in a row.
  task automatic run_seq(input bit reply, input bit chg, input logic [2:0] chg_val,
                         input int max_cyc);
    bit done_next  = 0;
    bit reply_next = 0;
    bit first      = 1;
    int idle_run   = 0;
    bit finished   = 0;
    sent.delete();
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      idle_inputs();
      if (reply_next) begin
        bus.byte_en = 1'b1;
        bus.rx_byte = 8'hFA;
        reply_next  = 0;
        if (chg && first) begin
          i_leds = chg_val;
          first  = 0;
        end
        #1 chk("seq_rsp_consume", 32'(bus.rsp_consume), 32'd1);
      end else if (done_next) begin
        bus.tx_done = 1'b1;
        done_next   = 0;
        reply_next  = reply;
      end else if (bus.tx_req) begin
        bus.tx_ack = 1'b1;
        done_next  = 1;
        sent.push_back(bus.tx_byte);
      end
      if (o_busy) idle_run = 0;
      else        idle_run++;
      if (idle_run >= 3) begin
        finished = 1;
        break;
      end
    end
    if (!finished) begin
      n_chk++;
      n_fail++;
      $display("FAIL seq_timeout: got busy after %0d cycles expected idle", max_cyc);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    i_aclr = 1'b1;
    i_leds = 3'b000;
    idle_inputs();
    repeat (3) @(negedge clk);
    i_aclr = 1'b0;

`ifdef KB_LED_CTRL_INIT_EN
    run_seq(1'b1, 1'b0, 3'b000, 100);
    chk("init_n_sent", 32'(sent.size()), 32'd2);
    if (sent.size() == 2) begin
      chk("init_byte0", 32'(sent[0]), 32'hED);
      chk("init_byte1", 32'(sent[1]), 32'h00);
    end
`endif

    // leds be b ack done | req txb busy cons app err
    add(3'b000, 0, 8'h00, 0, 0,  0, 8'h00, 0, 0, 3'b000, 0); // reset/idle
    add(3'b100, 0, 8'h00, 0, 0,  0, 8'h00, 0, 0, 3'b000, 0); // mismatch seen
    add(3'b100, 0, 8'h00, 0, 0,  1, 8'hED, 1, 0, 3'b000, 0); // SEND_CMD held
    add(3'b100, 0, 8'h00, 1, 0,  1, 8'hED, 1, 0, 3'b000, 0); // ack
    add(3'b100, 0, 8'h00, 1, 0,  0, 8'h00, 1, 0, 3'b000, 0); // stray ack ignored
    add(3'b100, 0, 8'h00, 0, 1,  0, 8'h00, 1, 0, 3'b000, 0); // done
    add(3'b100, 1, 8'h1C, 0, 0,  0, 8'h00, 1, 0, 3'b000, 0); // foreign byte in ACK1
    add(3'b100, 0, 8'h00, 0, 1,  0, 8'h00, 1, 0, 3'b000, 0); // stray done ignored
    add(3'b100, 1, 8'hFA, 0, 0,  0, 8'h00, 1, 1, 3'b000, 0); // ACK1
    add(3'b100, 0, 8'h00, 0, 0,  1, 8'h04, 1, 0, 3'b000, 0); // SEND_ARG
    add(3'b100, 0, 8'h00, 1, 0,  1, 8'h04, 1, 0, 3'b000, 0);
    add(3'b100, 0, 8'h00, 0, 1,  0, 8'h00, 1, 0, 3'b000, 0);
    add(3'b100, 1, 8'hFE, 0, 0,  0, 8'h00, 1, 1, 3'b000, 0); // resend
    add(3'b100, 0, 8'h00, 0, 0,  1, 8'h04, 1, 0, 3'b000, 0); // same byte again
    add(3'b100, 0, 8'h00, 1, 0,  1, 8'h04, 1, 0, 3'b000, 0);
    add(3'b100, 0, 8'h00, 0, 1,  0, 8'h00, 1, 0, 3'b000, 0);
    add(3'b100, 1, 8'h1C, 0, 0,  0, 8'h00, 1, 0, 3'b000, 0); // foreign byte in ACK2
    add(3'b100, 1, 8'hFA, 0, 0,  0, 8'h00, 1, 1, 3'b000, 0); // ACK2
    add(3'b100, 0, 8'h00, 0, 0,  0, 8'h00, 0, 0, 3'b100, 0); // committed
    add(3'b100, 0, 8'h00, 0, 0,  0, 8'h00, 0, 0, 3'b100, 0); // stays idle

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      i_leds      = tbl[i].leds;
      bus.byte_en = tbl[i].be;
      bus.rx_byte = tbl[i].b;
      bus.tx_ack  = tbl[i].ack;
      bus.tx_done = tbl[i].done;
      #1;
      chk($sformatf("r%0d_tx_req", i),  32'(bus.tx_req),      32'(tbl[i].req));
      chk($sformatf("r%0d_tx_byte", i), 32'(bus.tx_byte),     32'(tbl[i].txb));
      chk($sformatf("r%0d_busy", i),    32'(o_busy),          32'(tbl[i].busy));
      chk($sformatf("r%0d_consume", i), 32'(bus.rsp_consume), 32'(tbl[i].cons));
      chk($sformatf("r%0d_applied", i), 32'(o_leds_applied),  32'(tbl[i].app));
      chk($sformatf("r%0d_err", i),     32'(o_err),           32'(tbl[i].err));
    end
    @(negedge clk);
    idle_inputs();

    // Timeout abort: no reply ever, 0xED goes out 1 + MAX_RETRY times
    i_leds = 3'b010;
    run_seq(1'b0, 1'b0, 3'b000, 300);
    chk("abort_n_sent", 32'(sent.size()), 32'd4);
    foreach (sent[k]) chk($sformatf("abort_byte%0d", k), 32'(sent[k]), 32'hED);
    chk("abort_err",     32'(o_err),          32'd1);
    chk("abort_applied", 32'(o_leds_applied), 32'(3'b010));
    chk("abort_busy",    32'(o_busy),         32'd0);

    // Mid-sequence change: target stays latched, then a second sequence follows
    i_leds = 3'b001;
    run_seq(1'b1, 1'b1, 3'b011, 300);
    chk("chg_n_sent", 32'(sent.size()), 32'd4);
    if (sent.size() == 4) begin
      chk("chg_byte0", 32'(sent[0]), 32'hED);
      chk("chg_byte1", 32'(sent[1]), 32'h01);
      chk("chg_byte2", 32'(sent[2]), 32'hED);
      chk("chg_byte3", 32'(sent[3]), 32'h03);
    end
    chk("chg_applied", 32'(o_leds_applied), 32'(3'b011));
    chk("chg_err",     32'(o_err),          32'd0);

    // Async reset while in WAIT_ARG_DONE
    i_leds = 3'b000;
    @(negedge clk);
    @(negedge clk);
    #1 chk("rst_pre_cmd", 32'(bus.tx_req), 32'd1);
    bus.tx_ack = 1'b1;
    @(negedge clk);
    idle_inputs();
    bus.tx_done = 1'b1;
    @(negedge clk);
    idle_inputs();
    bus.byte_en = 1'b1;
    bus.rx_byte = 8'hFA;
    @(negedge clk);
    idle_inputs();
    #1 chk("rst_pre_arg_byte", 32'(bus.tx_byte), 32'h00);
    chk("rst_pre_arg_req", 32'(bus.tx_req), 32'd1);
    bus.tx_ack = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1 chk("rst_pre_busy", 32'(o_busy), 32'd1);
    i_aclr = 1'b1;
    #1;
    chk("rst_tx_req",  32'(bus.tx_req),      32'd0);
    chk("rst_tx_byte", 32'(bus.tx_byte),     32'h00);
    chk("rst_busy",    32'(o_busy),          32'd0);
    chk("rst_consume", 32'(bus.rsp_consume), 32'd0);
    chk("rst_applied", 32'(o_leds_applied),  32'(3'b000));
    chk("rst_err",     32'(o_err),           32'd0);
    repeat (2) @(negedge clk);
    i_aclr = 1'b0;
    @(negedge clk);
    #1;
`ifdef KB_LED_CTRL_INIT_EN
    chk("post_rst_req",  32'(bus.tx_req),  32'd1);
    chk("post_rst_byte", 32'(bus.tx_byte), 32'hED);
`else
    chk("post_rst_req",  32'(bus.tx_req), 32'd0);
    chk("post_rst_busy", 32'(o_busy),     32'd0);
    @(negedge clk);
    #1 chk("post_rst_busy2", 32'(o_busy), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/kb_led_ctrl.md
Name: kb_led_ctrl

Overview:
- Host-side sequencer that pushes lock-LED state (caps/num/scroll) to the PS/2 keyboard.
- Sits between keyboard-state logic (lock flags) and the PS/2 host transmitter.
- Listens to the receiver byte stream for device responses.
- Runs the 0xED + LED-byte exchange with ACK checking, resend handling, timeouts and a retry limit.
- Flags consumed response bytes so the keydown path ignores them.

Parameters:
- TIMEOUT_CYCLES, 2500000, clk cycles allowed in any WAIT_* state (50 ms at 50 MHz).
- MAX_RETRY, 3, retries per byte before abort.
- CNT_W, 22, timeout counter width; must hold TIMEOUT_CYCLES-1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- i_aclr  in  1  reset, asynchronous, active-high
- i_leds  in  3  requested LED state {caps,num,scroll}, maps to LED byte bits [2:0], bits [7:3]=0
- i_byte_en  in  1  one-cycle strobe, i_byte valid
- i_byte  in  8  byte received from keyboard
- o_tx_req  out  1  request transmitter to send o_tx_byte
- o_tx_byte  out  8  byte to transmit
- i_tx_ack  in  1  transmitter accepted request (1 cycle)
- i_tx_done  in  1  transmitter finished frame (1 cycle)
- o_busy  out  1  sequence in progress
- o_rsp_consume  out  1  current i_byte was taken as a response; downstream must drop it
- o_leds_applied  out  3  last LED state committed
- o_err  out  1  sticky abort flag

Behaviour:
- Reset (async, any state): state=IDLE, o_tx_req=0, o_tx_byte=0x00, o_busy=0, o_rsp_consume=0, o_leds_applied=0, o_err=0, retry=0, timer=0, target=0.
- States: IDLE, SEND_CMD, WAIT_CMD_DONE, WAIT_ACK1, SEND_ARG, WAIT_ARG_DONE, WAIT_ACK2.
- IDLE: start when i_leds != o_leds_applied (or pending flag, see optional feature).
  - Latch target<=i_leds, retry<=0, go to SEND_CMD.
  - o_busy is high from the next cycle until the return to IDLE.
- SEND_*: o_tx_req=1, o_tx_byte = 0xED (CMD) or {5'b0,target} (ARG), both held stable.
  - On i_tx_ack: o_tx_req drops next cycle; go to WAIT_*_DONE.
- WAIT_*_DONE: i_tx_done goes to WAIT_ACK1/2 and clears the timer.
- WAIT_ACK*, on i_byte_en:
  - 0xFA: advance. WAIT_ACK1 goes to SEND_ARG with retry<=0. WAIT_ACK2 goes to IDLE with o_leds_applied<=target and o_err<=0.
  - 0xFE: retry the same byte.
  - Any other value: not consumed, state unchanged.
- o_rsp_consume is combinational: high exactly in the cycle i_byte_en=1 and i_byte is 0xFA/0xFE in a WAIT_ACK state.
- Timer runs in all WAIT_* states and clears on every state change. Reaching TIMEOUT_CYCLES-1 counts as a retry event.
- Retry event:
  - If retry<MAX_RETRY: retry++, return to SEND_CMD (from the CMD phase) or SEND_ARG (from the ARG phase).
  - Else abort: o_err<=1, o_leds_applied<=target (prevents livelock), go to IDLE.
- i_leds changing mid-sequence is ignored (target latched). After return to IDLE the mismatch restarts a new sequence the next cycle.
- Simultaneous i_byte_en and timer expiry: the byte wins.
- i_tx_ack outside SEND_* and i_tx_done outside WAIT_*_DONE are ignored.

Optional Feature:
- KB_LED_CTRL_INIT_EN defined: a pending flag resets to 1, forcing one sequence after reset even if i_leds==0, which syncs the keyboard LEDs to off. The flag clears when the sequence starts.
- Undefined: no pending flag; a sequence starts only on mismatch.

Decomposition:
- Shared header kb_defs.vh: PS2_CMD_SET_LEDS=8'hED, PS2_RSP_ACK=8'hFA, PS2_RSP_RESEND=8'hFE, state encodings, LED bit indices.
- One sub-module, kb_timeout: clear/enable counter with expiry pulse, parameterised by TIMEOUT_CYCLES/CNT_W.

Test Plan:
- Normal update: i_leds 000->100, ack tx, done, feed 0xFA twice -> tx bytes 0xED then 0x04, o_leds_applied=100, o_err=0, two o_rsp_consume pulses.
- Resend: reply 0xFE to 0x04 -> 0x04 re-sent, then 0xFA completes, o_leds_applied=100.
- Timeout abort (TIMEOUT_CYCLES=16, MAX_RETRY=3): never reply in WAIT_ACK1 -> 0xED sent 4 times, o_err=1, o_leds_applied=target, IDLE.
- Foreign byte: scancode 0x1C during WAIT_ACK1 -> o_rsp_consume=0, state held, later 0xFA advances.
- Mid-sequence change: i_leds 001->011 during WAIT_ACK1 -> first sequence sends 0x01, then a second sequence sends 0xED, 0x03.
- Async reset in WAIT_ARG_DONE -> all outputs to reset values immediately. With KB_LED_CTRL_INIT_EN, 0xED is requested after release with i_leds=000.
